cmp_result_tracker: RTL

Sequential stage directly downstream of the 4-bit magnitude comparator. It consumes the comparator's equal / less_than / greater_than flags, qualified by a sample strobe, and keeps saturating per-outcome counters. It also runs a lock FSM that asserts after LOCK_LEN consecutive equal samples, flags direction reversals between less-than and greater-than, and records malformed flag codes.

---
 rtl/cmp_result_tracker.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cmp_result_tracker.sv
// cmp_result_tracker: registered tracker behind the 4-bit magnitude comparator.
// It keeps saturating per-outcome counters and a run length of consecutive
// equal samples. A lock FSM asserts after LOCK_LEN equal samples in a row.
// The block also flags lt<->gt direction reversals and keeps a sticky error
// bit for flag codes that are not one-hot.
//
// Handshake: the sample is accepted on a rising edge where in_valid=1. There
// is no ready signal, so the block accepts every cycle. The registered
// outputs show the effect of that sample from the next cycle onward. If clear
// is high on the same edge, the sample is dropped.
module cmp_result_tracker #(
  parameter int CNT_W    = 8,
  parameter int LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             equal,
  input  logic             less_than,
  input  logic             greater_than,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] gt_count,
  output logic [7:0]       run_len,
  output logic             locked,
  output logic             lock_pulse,
  output logic             dir_change,
  output logic [1:0]       last_result,
  output logic             code_err,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_LT   = 2'd1,
    DIR_GT   = 2'd2
  } dir_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [7:0]       LOCK_VAL = 8'(LOCK_LEN);

  state_t           state, state_n;
  dir_t             dir, dir_n;
  logic [CNT_W-1:0] eq_n, lt_n, gt_n;
  logic [7:0]       run_n;
  logic             lock_pulse_n, dir_change_n, code_err_n;
  logic [1:0]       last_n;
  logic             legal;

  // A sample is legal only when exactly one comparator flag is set.
  assign legal = in_valid && ({equal, less_than, greater_than} == 3'b100 ||
                              {equal, less_than, greater_than} == 3'b010 ||
                              {equal, less_than, greater_than} == 3'b001);

  assign locked    = (state == ST_LOCKED);
  assign fsm_state = state;

  // Compute the next state. By default everything holds and the pulses are cleared.
  always_comb begin
    state_n      = state;
    dir_n        = dir;
    eq_n         = eq_count;
    lt_n         = lt_count;
    gt_n         = gt_count;
    run_n        = run_len;
    last_n       = last_result;
    code_err_n   = code_err;
    lock_pulse_n = 1'b0;
    dir_change_n = 1'b0;
    if (in_valid && !legal) begin
      code_err_n = 1'b1;
    end else if (legal) begin
      if (equal) begin
        last_n = 2'b11;
        if (eq_count != CNT_MAX) eq_n = eq_count + 1'b1;
        run_n = (run_len == 8'hFF) ? 8'hFF : run_len + 8'd1;
        // The lock can fire from IDLE as well as HUNT, which matters when LOCK_LEN is 1.
        if (state != ST_LOCKED && run_n == LOCK_VAL) begin
          state_n      = ST_LOCKED;
          lock_pulse_n = 1'b1;
        end else if (state == ST_IDLE) begin
          state_n = ST_HUNT;
        end
      end else begin
        run_n   = 8'd0;
        state_n = ST_HUNT;
        if ((dir == DIR_LT && greater_than) || (dir == DIR_GT && less_than))
          dir_change_n = 1'b1;
        if (less_than) begin
          last_n = 2'b01;
          dir_n  = DIR_LT;
          if (lt_count != CNT_MAX) lt_n = lt_count + 1'b1;
        end else begin
          last_n = 2'b10;
          dir_n  = DIR_GT;
          if (gt_count != CNT_MAX) gt_n = gt_count + 1'b1;
        end
      end
    end
  end

  // Register all state. A synchronous clear takes priority over any sample on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      dir         <= DIR_NONE;
      eq_count    <= '0;
      lt_count    <= '0;
      gt_count    <= '0;
      run_len     <= 8'd0;
      last_result <= 2'b00;
      code_err    <= 1'b0;
      lock_pulse  <= 1'b0;
      dir_change  <= 1'b0;
    end else if (clear) begin
      state       <= ST_IDLE;
      dir         <= DIR_NONE;
      eq_count    <= '0;
      lt_count    <= '0;
      gt_count    <= '0;
      run_len     <= 8'd0;
      last_result <= 2'b00;
      code_err    <= 1'b0;
      lock_pulse  <= 1'b0;
      dir_change  <= 1'b0;
    end else begin
      state       <= state_n;
      dir         <= dir_n;
      eq_count    <= eq_n;
      lt_count    <= lt_n;
      gt_count    <= gt_n;
      run_len     <= run_n;
      last_result <= last_n;
      code_err    <= code_err_n;
      lock_pulse  <= lock_pulse_n;
      dir_change  <= dir_change_n;
    end
  end

endmodule
